// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port table memory family: FSM state
// encoding for the clear sequencer and the default geometry.
package mem_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int DATA_W_DEF = 4;
   localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/dual_port_ram_wr_if.sv
// Port bundle for the writable dual-port RAM: two read/write ports,
// the clear request, the busy flag and the collision pulse.
interface dual_port_ram_wr_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
);
   logic              clr;
   logic              busy;
   logic              ena;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina;
   logic [DATA_W-1:0] douta;
   logic              enb;
   logic              web;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] dinb;
   logic [DATA_W-1:0] doutb;
   logic              coll;

   // Requesting side: drives the ports, observes data and status.
   modport master (
      output clr, ena, wea, addra, dina, enb, web, addrb, dinb,
      input  busy, douta, doutb, coll
   );

   // Memory side.
   modport slave (
      input  clr, ena, wea, addra, dina, enb, web, addrb, dinb,
      output busy, douta, doutb, coll
   );
endinterface

// File: rtl/mem_clear_seq.sv
// Clear sequencer: after reset, or on a clr pulse while ready, sweeps every
// address once and supplies the write address/enable used to store the
// clear value. Ports are locked out (busy) for the whole sweep.
module mem_clear_seq
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;

   // State and sweep counter; reset starts a fresh sweep from address 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep until the last word is written (counter parks there,
   // no wrap), then stay ready until a clr pulse restarts the sweep.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Status and clear-write outputs follow directly from the current state.
   always_comb begin
      busy     = 1'b0;
      clr_we   = 1'b0;
      clr_addr = cnt_q;
      if (state_q == ST_CLEAR) begin
         busy   = 1'b1;
         clr_we = 1'b1;
      end
   end

endmodule

// File: rtl/dual_port_ram_wr.sv
// Writable dual-port RAM with read-first ports, same-address write
// collision detection (port A wins) and a built-in clear sweep that
// borrows the port-A write path while busy.
module dual_port_ram_wr
   import mem_pkg::*;
#(
   parameter int                DATA_W  = DATA_W_DEF,
   parameter int                ADDR_W  = ADDR_W_DEF,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input logic               clk,
   input logic               rst_n,
   dual_port_ram_wr_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic              wr_a_en;
   logic [ADDR_W-1:0] wr_a_addr;
   logic [DATA_W-1:0] wr_a_data;
   logic              wr_b_en;
   logic              rd_a_en;
   logic              rd_b_en;
   logic              coll_d;

   logic [DATA_W-1:0] douta_p1;
   logic [DATA_W-1:0] doutb_p1;
   logic              coll_p1;

   mem_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.clr),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // Port gating: the sweep owns the port-A write path while busy and all
   // external requests are dropped; collisions only count when ready.
   always_comb begin
      wr_a_en   = bus.ena & bus.wea;
      wr_a_addr = bus.addra;
      wr_a_data = bus.dina;
      wr_b_en   = bus.enb & bus.web;
      rd_a_en   = bus.ena;
      rd_b_en   = bus.enb;
      coll_d    = bus.ena & bus.wea & bus.enb & bus.web & (bus.addra == bus.addrb);
      if (busy) begin
         wr_a_en   = clr_we;
         wr_a_addr = clr_addr;
         wr_a_data = CLR_VAL;
         wr_b_en   = 1'b0;
         rd_a_en   = 1'b0;
         rd_b_en   = 1'b0;
         coll_d    = 1'b0;
      end
   end

   // Memory array: port A is written after port B so A's data wins on a
   // same-address collision.
   always_ff @(posedge clk) begin
      if (wr_b_en) begin
         mem[bus.addrb] <= bus.dinb;
      end
      if (wr_a_en) begin
         mem[wr_a_addr] <= wr_a_data;
      end
   end

   // ---- stage p1: registered read data (read-first) and collision pulse ----
   // Output registers; reads sample the pre-write content of this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         douta_p1 <= '0;
         doutb_p1 <= '0;
         coll_p1  <= 1'b0;
      end else begin
         if (rd_a_en) begin
            douta_p1 <= mem[bus.addra];
         end
         if (rd_b_en) begin
            doutb_p1 <= mem[bus.addrb];
         end
         coll_p1 <= coll_d;
      end
   end

   assign bus.busy  = busy;
   assign bus.douta = douta_p1;
   assign bus.doutb = doutb_p1;
   assign bus.coll  = coll_p1;

endmodule

// File: tb/tb_dual_port_ram_wr.sv
// Bench for dual_port_ram_wr: table-driven port vectors with hand-derived
// expected outputs, queued at drive time and compared one clock later,
// plus hand sequences for the reset, clear and mid-sweep reset cases.
module tb_dual_port_ram_wr;

   typedef struct {
      logic       clr;
      logic       ena;
      logic       wea;
      logic [2:0] addra;
      logic [3:0] dina;
      logic       enb;
      logic       web;
      logic [2:0] addrb;
      logic [3:0] dinb;
      logic [3:0] da;
      logic [3:0] db;
      logic       coll;
      logic       busy;
   } vec_t;

   typedef struct {
      logic [3:0] da;
      logic [3:0] db;
      logic       coll;
      logic       busy;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   exp_t exp_q[$];
   vec_t tbl[$];

   dual_port_ram_wr_if #(.DATA_W(4), .ADDR_W(3)) bus ();

   dual_port_ram_wr #(
      .DATA_W  (4),
      .ADDR_W  (3),
      .CLR_VAL (4'h0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input int c, input int ea, input int wa, input int aa,
                               input int da_in, input int eb, input int wb, input int ab,
                               input int db_in, input int xa, input int xb,
                               input int xc, input int xbusy);
      vec_t v;
      v.clr   = 1'(c);
      v.ena   = 1'(ea);
      v.wea   = 1'(wa);
      v.addra = 3'(aa);
      v.dina  = 4'(da_in);
      v.enb   = 1'(eb);
      v.web   = 1'(wb);
      v.addrb = 3'(ab);
      v.dinb  = 4'(db_in);
      v.da    = 4'(xa);
      v.db    = 4'(xb);
      v.coll  = 1'(xc);
      v.busy  = 1'(xbusy);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      bus.clr   = v.clr;
      bus.ena   = v.ena;
      bus.wea   = v.wea;
      bus.addra = v.addra;
      bus.dina  = v.dina;
      bus.enb   = v.enb;
      bus.web   = v.web;
      bus.addrb = v.addrb;
      bus.dinb  = v.dinb;
      e.da   = v.da;
      e.db   = v.db;
      e.coll = v.coll;
      e.busy = v.busy;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.clr = 1'b0;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, expected one entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " douta"}, {4'h0, bus.douta}, {4'h0, e.da});
         chk({tag, " doutb"}, {4'h0, bus.doutb}, {4'h0, e.db});
         chk({tag, " coll"},  {7'h0, bus.coll},  {7'h0, e.coll});
         chk({tag, " busy"},  {7'h0, bus.busy},  {7'h0, e.busy});
      end
   endtask

   task automatic run_tbl(input string tag);
      foreach (tbl[i]) begin
         apply(tbl[i], $sformatf("%s[%0d]", tag, i));
      end
      tbl.delete();
   endtask

   task automatic idle_inputs();
      bus.clr   = 1'b0;
      bus.ena   = 1'b0;
      bus.wea   = 1'b0;
      bus.addra = '0;
      bus.dina  = '0;
      bus.enb   = 1'b0;
      bus.web   = 1'b0;
      bus.addrb = '0;
      bus.dinb  = '0;
   endtask

   // Count clocks from reset release until busy falls (bounded).
   task automatic count_busy(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.busy && n < 20);
      chk(tag, 8'(n), 8'd8);
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         tbl.push_back(mk(0, 1,0,i,0, 1,0,7-i,0, 0,0,0,0));
      end
      run_tbl(tag);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      idle_inputs();

      // Reset state and initial sweep length.
      rst_n = 1'b0;
      #12;
      chk("reset douta", {4'h0, bus.douta}, 8'h00);
      chk("reset doutb", {4'h0, bus.doutb}, 8'h00);
      chk("reset coll",  {7'h0, bus.coll},  8'h00);
      chk("reset busy",  {7'h0, bus.busy},  8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy("initial busy clocks");
      read_all_zero("init_read");

      // Main port behaviour, all hand-derived expectations.
      tbl.push_back(mk(0, 1,1,3,'hA, 0,0,0,0,     0,   0,   0,0));
      tbl.push_back(mk(0, 0,0,0,0,   1,0,3,0,     0,   'hA, 0,0));
      tbl.push_back(mk(0, 1,1,5,6,   1,1,5,9,     0,   0,   1,0));
      tbl.push_back(mk(0, 1,0,5,0,   0,0,0,0,     6,   0,   0,0));
      tbl.push_back(mk(0, 1,1,2,1,   0,0,0,0,     0,   0,   0,0));
      tbl.push_back(mk(0, 1,1,2,'hF, 1,0,2,0,     1,   1,   0,0));
      tbl.push_back(mk(0, 0,0,0,0,   1,0,2,0,     1,   'hF, 0,0));
      tbl.push_back(mk(0, 1,0,3,0,   1,0,3,0,     'hA, 'hA, 0,0));
      tbl.push_back(mk(0, 1,1,7,'hC, 1,1,6,'hD,   0,   0,   0,0));
      tbl.push_back(mk(0, 1,0,6,0,   1,0,7,0,     'hD, 'hC, 0,0));
      tbl.push_back(mk(0, 1,1,7,3,   1,1,7,4,     'hC, 'hC, 1,0));
      tbl.push_back(mk(0, 0,1,0,'hF, 1,0,7,0,     'hC, 3,   0,0));
      tbl.push_back(mk(0, 1,0,0,0,   0,0,0,0,     0,   3,   0,0));
      tbl.push_back(mk(0, 1,1,0,5,   1,0,0,0,     0,   0,   0,0));
      tbl.push_back(mk(0, 0,0,0,0,   1,0,0,0,     0,   5,   0,0));
      tbl.push_back(mk(0, 1,0,4,0,   1,1,4,7,     0,   0,   0,0));
      tbl.push_back(mk(0, 1,0,4,0,   0,0,0,0,     7,   0,   0,0));
      run_tbl("main");

      // clr with same-cycle port activity, then dropped requests while busy
      // (including a second clr that must not restart the sweep).
      tbl.push_back(mk(1, 1,0,5,0, 1,1,1,9, 6,0,0,1));
      for (int k = 0; k < 8; k++) begin
         tbl.push_back(mk((k == 2) ? 1 : 0, 1,1,k,'hF, 1,1,k,'hE, 6,0,0, (k < 7) ? 1 : 0));
      end
      run_tbl("clear");
      read_all_zero("post_clear_read");

      // Reset in the middle of a sweep.
      tbl.push_back(mk(0, 1,1,3,'hA, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1, 1,0,3,0,   1,0,3,0, 'hA,'hA,0,1));
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 'hA,'hA,0,1));
      end
      run_tbl("midsweep");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset douta", {4'h0, bus.douta}, 8'h00);
      chk("midreset doutb", {4'h0, bus.doutb}, 8'h00);
      chk("midreset coll",  {7'h0, bus.coll},  8'h00);
      chk("midreset busy",  {7'h0, bus.busy},  8'h01);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      count_busy("restart busy clocks");
      tbl.push_back(mk(0, 1,0,3,0, 1,0,7,0, 0,0,0,0));
      run_tbl("after_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
